jedro_1_ifu: RTL and testbench
==============================

# jedro_1_ifu

Instruction fetch unit for the jedro_1 core. Issues word reads to the synchronous instruction ROM over the `ram_read_io` master modport and buffers returned instructions with their addresses in a small prefetch FIFO. It hands instructions to the decoder with a valid/ready handshake. Jump and branch redirects from the execute stage flush the FIFO and any in-flight read, then restart fetching at the new address.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 32: byte address width.
- `BOOT_ADDR`, 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, 4: prefetch entries. Must be a power of two, at least 2.

**Ports**
- `clk_i`, in, 1: clock, rising edge.
- `rstn_i`, in, 1: reset, asynchronous, active-low.
- `instr_mem_if`, `ram_read_io.MASTER`, ADDR_WIDTH/DATA_WIDTH: ROM read port. Read data is returned one cycle after the address is presented.
- `instr_o`, out, DATA_WIDTH: instruction at the FIFO head.
- `addr_o`, out, ADDR_WIDTH: byte address of `instr_o`.
- `valid_o`, out, 1: head entry is valid.
- `ready_i`, in, 1: decoder accepts the head entry when `valid_o && ready_i`.
- `jmp_addr_i`, in, ADDR_WIDTH: redirect target.
- `jmp_valid_i`, in, 1: redirect request, one-cycle pulse.
- `fetch_err_o`, out, 1: misaligned redirect flag. Only present with the macro.

## Operation

- **Fetch PC**
  - Register `pc_r`, reset to `BOOT_ADDR`.
  - Incremented by 4 for each read issued.
- **Issue rule**
  - A read of `pc_r` is issued in a cycle when `occupancy + inflight < FIFO_DEPTH` and no redirect is present.
  - `inflight` is 0 or 1.
- **Response**
  - One cycle after issue, the pair `{address, rdata}` is pushed into the FIFO, unless it was squashed.
- **Output**
  - `valid_o = !empty`.
  - `instr_o` and `addr_o` show the head entry.
  - The head pops on `valid_o && ready_i`.
- **Redirect** (`jmp_valid_i`)
  - In the same cycle: FIFO cleared, in-flight response marked squashed, `pc_r <= jmp_addr_i`, no read issued.
  - A handshake in that cycle is ignored; the head is discarded, not consumed.
  - Fetching resumes the next cycle.
- **Simultaneous push and pop when full**
  - Allowed. Occupancy is unchanged.
- **Wrap-around**
  - `pc_r` wraps modulo 2^ADDR_WIDTH without error.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- **Reset mid-operation**
  - All state clears asynchronously.
  - Any outstanding ROM response is ignored because `inflight` is cleared.
- **Reset values**
  - `valid_o` = 0, `instr_o` = 0, `addr_o` = 0, `fetch_err_o` = 0.
  - ROM read address = `BOOT_ADDR`.

## Timing

- **Cycle 0** (first edge after `rstn_i` rises): read of `BOOT_ADDR` issued.
- **Cycle 1:** data returns and is pushed.
- **Cycle 2:** `valid_o` = 1.
- **Startup latency:** 2 cycles from first issue to valid output.
- **Throughput:** with `ready_i` held high, one instruction per cycle from cycle 2 onward, with consecutive addresses.
- **Redirect latency:** redirect in cycle N, first target read in cycle N+1, `valid_o` in cycle N+3. `valid_o` is 0 in cycles N+1 and N+2.
- **Backpressure:** with `ready_i` = 0, fetching stops once occupancy + inflight = FIFO_DEPTH. No entry is lost or duplicated.

## Configuration

- **Macro:** `JEDRO_1_IFU_FETCH_ERR_EN`.
- **Defined:**
  - A redirect with `jmp_addr_i[1:0] != 0` sets `fetch_err_o` the next cycle.
  - The unit then issues no reads and keeps `valid_o` = 0.
  - It stays in that state until an aligned redirect arrives, which clears `fetch_err_o` in the same cycle as it takes effect.
- **Undefined:**
  - `fetch_err_o` is absent.
  - `jmp_addr_i[1:0]` is forced to 0.

## Structure

- **`jedro_1_pkg`:**
  - `ifu_entry_t`, a packed struct holding address and instruction.
  - `INSTR_BYTES = 4`.
  - `BOOT_ADDR` default.
- **Sub-module `jedro_1_ifu_fifo`:**
  - Synchronous FIFO of `ifu_entry_t`.
  - Ports: push, pop, flush, count, empty, full.
  - Flush has priority over push.
- **Top level:** contains the PC, the issue logic and the squash logic.

## Test plan

- **Reset and streaming:** ROM holds 0x13, 0x93, 0x113, ... at addresses 0, 4, 8. Release reset with `ready_i` = 1. Expect `valid_o` in cycle 2, then `addr_o` = 0, 4, 8 on consecutive cycles with matching `instr_o`.
- **Backpressure:** hold `ready_i` = 0 for 10 cycles. Expect at most 4 reads issued and the FIFO full at address 0. On release, addresses 0, 4, 8, 12, 16 appear with no gap or duplicate.
- **Redirect:** pulse `jmp_valid_i` with `jmp_addr_i` = 0x40 while the FIFO holds 0x8 and 0xC. Expect `valid_o` = 0 for 2 cycles, then `addr_o` = 0x40. No 0x10 response ever appears.
- **Redirect plus handshake:** redirect in the same cycle as `valid_o && ready_i`. Expect the head discarded and the next output at the target.
- **Misaligned redirect:** with `JEDRO_1_IFU_FETCH_ERR_EN`, redirect to 0x42. Expect `fetch_err_o` = 1 and no reads issued. A following redirect to 0x44 clears the flag and fetches 0x44.
- **Async reset mid-stream:** assert `rstn_i` low between clock edges. Expect outputs at reset values immediately, and fetch restarting at `BOOT_ADDR` after release.

Source files
------------

// File: rtl/jedro_1_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch path.
package jedro_1_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] instr;
   } ifu_entry_t;

endpackage

// File: rtl/ram_read_io.sv
// Read port of a synchronous memory: data returns one cycle after the address.
interface ram_read_io #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  en;
   logic [DATA_WIDTH-1:0] rdata;

   modport MASTER (output addr, output en, input rdata);
   modport SLAVE  (input addr, input en, output rdata);
endinterface

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch FIFO for fetched instructions; flush wins over push, push+pop when full is allowed.
module jedro_1_ifu_fifo
   import jedro_1_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = ifu_entry_t
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  entry_t                   wdata,
   output entry_t                   rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
   end

   // NOTE: storage has no reset; stale contents are never visible because the top masks the head when empty.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: PC, read issue, squash on redirect, prefetch FIFO.
// Optional misaligned-redirect flag enabled by `define JEDRO_1_IFU_FETCH_ERR_EN.
module jedro_1_ifu
   import jedro_1_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(DEFAULT_BOOT_ADDR),
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   ram_read_io.MASTER            instr_mem_if,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
   input  logic                  jmp_valid_i
`ifdef JEDRO_1_IFU_FETCH_ERR_EN
   ,
   output logic                  fetch_err_o
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] instr;
   } entry_t;

   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] inflight_addr_r;
   logic [ADDR_WIDTH-1:0] jmp_target;
   logic                  inflight_r;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  room;
   logic                  fetch_err;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [CNT_W-1:0]      fifo_count;
   entry_t                push_entry;
   entry_t                head_entry;

`ifdef JEDRO_1_IFU_FETCH_ERR_EN
   logic fetch_err_r;

   assign jmp_target = jmp_addr_i;

   // Error latches on a misaligned redirect and is cleared only by an aligned one.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)          fetch_err_r <= 1'b0;
      else if (jmp_valid_i) fetch_err_r <= |jmp_addr_i[1:0];
   end

   assign fetch_err   = fetch_err_r;
   assign fetch_err_o = fetch_err_r;
`else
   assign jmp_target = jmp_addr_i & ~ADDR_WIDTH'(INSTR_BYTES - 1);
   assign fetch_err  = 1'b0;
`endif

   // Count the outstanding read as occupied so its response always has a slot.
   assign room  = !fifo_full && ((fifo_count + CNT_W'(inflight_r)) < CNT_W'(FIFO_DEPTH));
   assign issue = room && !jmp_valid_i && !fetch_err;

   // A response landing in a redirect cycle is squashed; the flush also wins inside the FIFO.
   assign push = inflight_r && !jmp_valid_i;
   assign pop  = !fifo_empty && ready_i && !jmp_valid_i;

   assign instr_mem_if.addr = pc_r;
   assign instr_mem_if.en   = issue;

   assign push_entry.addr  = inflight_addr_r;
   assign push_entry.instr = instr_mem_if.rdata;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pc_r            <= BOOT_ADDR;
         inflight_r      <= 1'b0;
         inflight_addr_r <= '0;
      end else if (jmp_valid_i) begin
         pc_r       <= jmp_target;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= issue;
         if (issue) begin
            pc_r            <= pc_r + ADDR_WIDTH'(INSTR_BYTES);
            inflight_addr_r <= pc_r;
         end
      end
   end

   jedro_1_ifu_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .push   (push),
      .pop    (pop),
      .flush  (jmp_valid_i),
      .wdata  (push_entry),
      .rdata  (head_entry),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   assign valid_o = !fifo_empty;
   assign instr_o = fifo_empty ? '0 : head_entry.instr;
   assign addr_o  = fifo_empty ? '0 : head_entry.addr;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: directed scenarios plus randomized traffic vs. a stream model.
module tb_jedro_1_ifu;

   localparam int          AW    = 32;
   localparam int          DW    = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BOOT  = 32'h0000_0000;

   logic        clk_i       = 1'b0;
   logic        rstn_i      = 1'b0;
   logic        ready_i     = 1'b0;
   logic        jmp_valid_i = 1'b0;
   logic [31:0] jmp_addr_i  = '0;
   logic [31:0] instr_o;
   logic [31:0] addr_o;
   logic        valid_o;
`ifdef JEDRO_1_IFU_FETCH_ERR_EN
   logic        fetch_err_o;
`endif

   always #5 clk_i = ~clk_i;

   ram_read_io #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom_if ();

   jedro_1_ifu #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BOOT_ADDR  (BOOT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .instr_mem_if (rom_if),
      .instr_o      (instr_o),
      .addr_o       (addr_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .jmp_addr_i   (jmp_addr_i),
      .jmp_valid_i  (jmp_valid_i)
`ifdef JEDRO_1_IFU_FETCH_ERR_EN
      ,
      .fetch_err_o  (fetch_err_o)
`endif
   );

   // ROM image: 0x13, 0x93, 0x113, ... at 0, 4, 8.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a << 5) + 32'h13;
   endfunction

   always @(posedge clk_i) rom_if.rdata <= rom_word(rom_if.addr);

   int unsigned reads;
   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)          reads <= 0;
      else if (rom_if.en)   reads <= reads + 1;
   end

   int errors = 0;
   int checks = 0;

   // Stream model: next address the decoder must receive, cycles since restart, reads not yet consumed.
   logic [31:0] exp_next;
   int          since;
   int          outstanding;
   logic        err_model;
   logic        last_iss;

   task automatic advance();
      logic hs;
      hs       = valid_o && ready_i && !jmp_valid_i;
      last_iss = rom_if.en;
      if (jmp_valid_i) begin
`ifdef JEDRO_1_IFU_FETCH_ERR_EN
         exp_next  = jmp_addr_i;
         err_model = |jmp_addr_i[1:0];
`else
         exp_next  = jmp_addr_i & ~32'h3;
`endif
         since       = 0;
         outstanding = 0;
      end else begin
         if (hs) begin
            exp_next    = exp_next + 32'd4;
            outstanding = outstanding - 1;
         end
         if (last_iss) outstanding = outstanding + 1;
         since = since + 1;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic restart_model();
      exp_next    = BOOT;
      since       = 0;
      outstanding = 0;
      err_model   = 1'b0;
   endtask

   task automatic apply_reset();
      rstn_i      = 1'b0;
      ready_i     = 1'b0;
      jmp_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      restart_model();
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      ready_i = 1'b1;
      #12;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_o); end
      checks++; if (addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_o); end
      checks++; if (rom_if.addr !== BOOT) begin errors++; $display("FAIL reset_rom_addr: got %h want %h", rom_if.addr, BOOT); end
      @(negedge clk_i);
      rstn_i = 1'b1;
      restart_model();
      #1;
      checks++; if (rom_if.en !== 1'b1) begin errors++; $display("FAIL cycle0_issue: got %b want 1", rom_if.en); end
      advance();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL cycle1_valid: got %b want 0", valid_o); end
      advance();
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h0 || instr_o !== 32'h13) begin
         errors++; $display("FAIL cycle2_first: got v=%b a=%h i=%h want v=1 a=0 i=13", valid_o, addr_o, instr_o);
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if (valid_o !== 1'b1 || addr_o !== exp_next || instr_o !== rom_word(exp_next)) begin
            errors++; $display("FAIL stream[%0d]: got v=%b a=%h i=%h want a=%h i=%h", i, valid_o, addr_o, instr_o, exp_next, rom_word(exp_next));
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      repeat (10) begin #1; advance(); end
      checks++; if (reads !== 4) begin errors++; $display("FAIL bp_reads: got %0d want 4", reads); end
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b a=%h want v=1 a=0", valid_o, addr_o); end
      ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (valid_o !== 1'b1 || addr_o !== 32'(i * 4) || instr_o !== rom_word(32'(i * 4))) begin
            errors++; $display("FAIL bp_drain[%0d]: got v=%b a=%h want a=%h", i, valid_o, addr_o, 32'(i * 4));
         end
         advance();
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      repeat (5) begin #1; advance(); end
      ready_i = 1'b1;
      repeat (2) begin #1; advance(); end
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h8) begin errors++; $display("FAIL rd_pre_head: got v=%b a=%h want a=8", valid_o, addr_o); end
      ready_i     = 1'b0;
      jmp_valid_i = 1'b1;
      jmp_addr_i  = 32'h40;
      #1;
      checks++; if (rom_if.en !== 1'b0) begin errors++; $display("FAIL rd_no_issue: got %b want 0", rom_if.en); end
      advance();
      jmp_valid_i = 1'b0;
      ready_i     = 1'b1;
      #1;
      checks++; if (valid_o !== 1'b0 || rom_if.en !== 1'b1 || rom_if.addr !== 32'h40) begin
         errors++; $display("FAIL rd_n1: got v=%b en=%b ra=%h want v=0 en=1 ra=40", valid_o, rom_if.en, rom_if.addr);
      end
      advance();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rd_n2_valid: got %b want 0", valid_o); end
      advance();
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (valid_o !== 1'b1 || addr_o === 32'h10 || addr_o !== exp_next || instr_o !== rom_word(exp_next)) begin
            errors++; $display("FAIL rd_after[%0d]: got v=%b a=%h want a=%h", i, valid_o, addr_o, exp_next);
         end
         advance();
      end
   endtask

   task automatic test_redirect_handshake();
      #1;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rh_pre_valid: got %b want 1", valid_o); end
      jmp_valid_i = 1'b1;
      jmp_addr_i  = 32'h100;
      advance();
      jmp_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rh_gap[%0d]: got %b want 0", i, valid_o); end
         advance();
      end
      #1;
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h100 || instr_o !== rom_word(32'h100)) begin
         errors++; $display("FAIL rh_target: got v=%b a=%h want a=100", valid_o, addr_o);
      end
      advance();
   endtask

   task automatic test_unaligned();
      int unsigned r0;
      jmp_valid_i = 1'b1;
      jmp_addr_i  = 32'h42;
      advance();
      jmp_valid_i = 1'b0;
`ifdef JEDRO_1_IFU_FETCH_ERR_EN
      r0 = reads;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (fetch_err_o !== 1'b1 || valid_o !== 1'b0 || rom_if.en !== 1'b0) begin
            errors++; $display("FAIL ua_err[%0d]: got err=%b v=%b en=%b want err=1 v=0 en=0", i, fetch_err_o, valid_o, rom_if.en);
         end
         advance();
      end
      checks++; if (reads !== r0) begin errors++; $display("FAIL ua_reads: got %0d want %0d", reads, r0); end
      jmp_valid_i = 1'b1;
      jmp_addr_i  = 32'h44;
      #1;
      advance();
      jmp_valid_i = 1'b0;
      #1;
      checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL ua_clear: got %b want 0", fetch_err_o); end
      advance();
      advance();
      #1;
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h44) begin errors++; $display("FAIL ua_fetch: got v=%b a=%h want a=44", valid_o, addr_o); end
      advance();
`else
      r0 = 0;
      advance();
      advance();
      #1;
      checks++; if (valid_o !== 1'b1 || addr_o !== 32'h40 || addr_o !== exp_next) begin
         errors++; $display("FAIL ua_masked: got v=%b a=%h want a=40 (r0=%0d)", valid_o, addr_o, r0);
      end
      advance();
`endif
   endtask

   task automatic test_random();
      logic [31:0] pool [4];
      pool[0] = 32'hFFFF_FFF8;
      pool[1] = 32'h0000_0200;
      pool[2] = 32'h1234_5670;
      pool[3] = 32'h0000_0010;
      for (int i = 0; i < 400; i++) begin
         ready_i     = ($urandom_range(0, 3) != 0);
         jmp_valid_i = ($urandom_range(0, 11) == 0);
         jmp_addr_i  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : ($urandom & 32'hFFFF_FFF0);
`ifndef JEDRO_1_IFU_FETCH_ERR_EN
         jmp_addr_i  = jmp_addr_i | 32'($urandom_range(0, 3));
`endif
         #1;
         checks++; if (valid_o !== (since >= 2)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_o, since >= 2); end
         if (valid_o && ready_i && !jmp_valid_i) begin
            checks++; if (addr_o !== exp_next || instr_o !== rom_word(exp_next)) begin
               errors++; $display("FAIL rnd_data[%0d]: got a=%h i=%h want a=%h i=%h", i, addr_o, instr_o, exp_next, rom_word(exp_next));
            end
         end
         if (jmp_valid_i) begin
            checks++; if (rom_if.en !== 1'b0) begin errors++; $display("FAIL rnd_jmp_issue[%0d]: got %b want 0", i, rom_if.en); end
         end
         advance();
         checks++; if (outstanding < 0 || outstanding > DEPTH) begin errors++; $display("FAIL rnd_occ[%0d]: got %0d want 0..%0d", i, outstanding, DEPTH); end
      end
      jmp_valid_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b1;
      repeat (4) begin #1; advance(); end
      #2;
      rstn_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || addr_o !== 32'h0 || rom_if.addr !== BOOT) begin
         errors++; $display("FAIL mid_reset: got v=%b i=%h a=%h ra=%h want 0 0 0 %h", valid_o, instr_o, addr_o, rom_if.addr, BOOT);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      restart_model();
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++; if (valid_o !== (since >= 2) || (valid_o && (addr_o !== exp_next || instr_o !== rom_word(exp_next)))) begin
            errors++; $display("FAIL mid_restart[%0d]: got v=%b a=%h want v=%b a=%h", i, valid_o, addr_o, since >= 2, exp_next);
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect();
      test_redirect_handshake();
      test_unaligned();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
